// File: rtl/buscaminas_pkg.sv
// Shared types and constants for the minesweeper neighbour scanner.
// Holds the FSM state set and the neighbour offset tables.
package buscaminas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    EVAL,
    N_ADDR,
    N_DATA,
    WRITE,
    DONE
  } bm_state_t;

  localparam logic [3:0] CNT_BOMB = 4'hF;
  localparam logic [2:0] NB_LAST  = 3'd7;

  // Row/col offsets of the 8 neighbours, row-major around the cell.
  localparam logic signed [1:0] NB_DR [8] = '{
    -2'sd1, -2'sd1, -2'sd1,
     2'sd0,          2'sd0,
     2'sd1,  2'sd1,  2'sd1
  };
  localparam logic signed [1:0] NB_DC [8] = '{
    -2'sd1,  2'sd0,  2'sd1,
    -2'sd1,          2'sd1,
    -2'sd1,  2'sd0,  2'sd1
  };

endpackage

// File: rtl/buscaminas_neighbor_addr.sv
// Neighbour address generator: cell + offset[idx], with a board range flag.
// Negative results wrap to large unsigned values and fail the range test.
module buscaminas_neighbor_addr
  import buscaminas_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic [2:0]    idx,
  output logic [RW-1:0] n_row,
  output logic [CW-1:0] n_col,
  output logic          in_range
);

  logic signed [1:0] dr;
  logic signed [1:0] dc;
  logic [RW:0]       r_ext;
  logic [CW:0]       c_ext;

  // One extra bit lets -1 and +max both land above the board limit.
  always_comb begin
    dr       = NB_DR[idx];
    dc       = NB_DC[idx];
    r_ext    = {1'b0, row} + {{RW{dr[1]}}, dr[0]};
    c_ext    = {1'b0, col} + {{CW{dc[1]}}, dc[0]};
    in_range = (r_ext <= (RW+1)'(ROWS-1))
            && (c_ext <= (CW+1)'(COLS-1));
    n_row    = r_ext[RW-1:0];
    n_col    = c_ext[CW-1:0];
  end

endmodule

// File: rtl/buscaminas_neighbor_counter.sv
// Board scanner: writes each cell's neighbour bomb count (or a bomb
// marker) into the count memory, walking the bomb map in row-major order.
module buscaminas_neighbor_counter
  import buscaminas_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS),
  parameter int TW   = $clog2(ROWS*COLS+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [RW-1:0] bomb_rd_row,
  output logic [CW-1:0] bomb_rd_col,
  input  logic          bomb_rd_data,
  output logic          cnt_we,
  output logic [RW-1:0] cnt_row,
  output logic [CW-1:0] cnt_col,
  output logic [3:0]    cnt_data,
  output logic          busy,
  output logic          ultima_casilla,
  output logic          done,
  output logic [TW-1:0] bombs_total
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS-1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS-1);
  localparam logic [TW-1:0] TOTAL   = TW'(ROWS*COLS);

  bm_state_t     state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [2:0]    idx;
  logic [3:0]    acc;
  logic [3:0]    acc_sum;
  logic [RW-1:0] n_row;
  logic [CW-1:0] n_col;
  logic          in_range;
  logic [RW-1:0] nxt_row;
  logic [CW-1:0] nxt_col;
  logic          nxt_last;
  logic          last_cell;

  buscaminas_neighbor_addr #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW),
    .CW   (CW)
  ) u_addr (
    .row      (row),
    .col      (col),
    .idx      (idx),
    .n_row    (n_row),
    .n_col    (n_col),
    .in_range (in_range)
  );

  // Next cell in row-major order and end-of-board detection.
  always_comb begin
    if (col == COL_MAX) begin
      nxt_col = '0;
      nxt_row = row + 1'b1;
    end else begin
      nxt_col = col + 1'b1;
      nxt_row = row;
    end
    nxt_last  = (nxt_row == ROW_MAX) && (nxt_col == COL_MAX);
    last_cell = (row == ROW_MAX) && (col == COL_MAX);
    acc_sum   = acc + {3'b000, bomb_rd_data};
  end

  // Read address only driven for the cell itself or an in-board neighbour.
  always_comb begin
    bomb_rd_row = '0;
    bomb_rd_col = '0;
    if (state == CHECK) begin
      bomb_rd_row = row;
      bomb_rd_col = col;
    end else if (state == N_ADDR && in_range) begin
      bomb_rd_row = n_row;
      bomb_rd_col = n_col;
    end
  end

  // Scan FSM with registered write port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      row            <= '0;
      col            <= '0;
      idx            <= '0;
      acc            <= '0;
      cnt_we         <= 1'b0;
      cnt_row        <= '0;
      cnt_col        <= '0;
      cnt_data       <= '0;
      busy           <= 1'b0;
      ultima_casilla <= 1'b0;
      done           <= 1'b0;
      bombs_total    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            row         <= '0;
            col         <= '0;
            bombs_total <= '0;
            busy        <= 1'b1;
            state       <= CHECK;
          end
        end
        CHECK: state <= EVAL;
        EVAL: begin
          if (bomb_rd_data) begin
            if (bombs_total != TOTAL)
              bombs_total <= bombs_total + 1'b1;
            cnt_data <= CNT_BOMB;
            cnt_row  <= row;
            cnt_col  <= col;
            cnt_we   <= 1'b1;
            state    <= WRITE;
          end else begin
            acc   <= '0;
            idx   <= '0;
            state <= N_ADDR;
          end
        end
        N_ADDR: begin
          if (in_range) begin
            state <= N_DATA;
          end else if (idx == NB_LAST) begin
            cnt_data <= acc;
            cnt_row  <= row;
            cnt_col  <= col;
            cnt_we   <= 1'b1;
            state    <= WRITE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        N_DATA: begin
          acc <= acc_sum;
          if (idx == NB_LAST) begin
            cnt_data <= acc_sum;
            cnt_row  <= row;
            cnt_col  <= col;
            cnt_we   <= 1'b1;
            state    <= WRITE;
          end else begin
            idx   <= idx + 1'b1;
            state <= N_ADDR;
          end
        end
        WRITE: begin
          cnt_we <= 1'b0;
          if (last_cell) begin
            ultima_casilla <= 1'b0;
            done           <= 1'b1;
            state          <= DONE;
          end else begin
            row            <= nxt_row;
            col            <= nxt_col;
            ultima_casilla <= nxt_last;
            state          <= CHECK;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/buscaminas_neighbor_counter.md
# buscaminas_neighbor_counter

Parametrised Buscaminas (minesweeper) board-scanner FSM, the generalised successor of the fixed 3-bit cell-check state machine. After a `start` pulse it walks every cell of a ROWS×COLS bomb map, counts bombs among the 8 neighbours of each non-bomb cell, and writes the count to the count memory. Bomb cells are written with a marker value. It sits between the board-generation logic (which fills the bomb map) and the display/play logic (which reads the count memory).

## Interface
Parameters:
- ROWS, 8, board rows (≥2)
- COLS, 8, board columns (≥2)
- RW, $clog2(ROWS), row index width (derived)
- CW, $clog2(COLS), column index width (derived)
- TW, $clog2(ROWS*COLS+1), bomb-total width (derived)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin scan; sampled only in IDLE
- bomb_rd_row  out  RW  bomb-map read row
- bomb_rd_col  out  CW  bomb-map read column
- bomb_rd_data  in  1  bomb bit, valid one cycle after address
- cnt_we  out  1  count-memory write strobe
- cnt_row  out  RW  write row
- cnt_col  out  CW  write column
- cnt_data  out  4  neighbour count 0–8, or 4'hF for a bomb cell
- busy  out  1  high from the cycle after start acceptance until DONE exits
- ultima_casilla  out  1  high while the last cell (ROWS-1, COLS-1) is processed
- done  out  1  one-cycle pulse at end of scan
- bombs_total  out  TW  bomb cells found; cleared on start, held after done

## Operation
- States: IDLE, CHECK, EVAL, N_ADDR, N_DATA, WRITE, DONE.
- IDLE: outputs idle. `start`=1 → clear row, col, and bombs_total → CHECK.
- CHECK: drive the cell address on bomb_rd_* → EVAL.
- EVAL: bomb_rd_data is valid.
  - If 1: bombs_total++, cnt_data=4'hF → WRITE.
  - If 0: clear the accumulator and set idx=0 → N_ADDR.
- Neighbour order idx 0..7: (-1,-1), (-1,0), (-1,+1), (0,-1), (0,+1), (+1,-1), (+1,0), (+1,+1).
- N_ADDR, neighbour in range: drive its address → N_DATA.
- N_ADDR, neighbour out of range: no read. idx++ → N_ADDR, or → WRITE if idx was 7.
- N_DATA: acc += bomb_rd_data. idx++ → N_ADDR, or → WRITE if idx was 7.
- WRITE: cnt_we=1 for one cycle, with cnt_row/col = current cell and cnt_data = acc or 4'hF.
  - Last cell → DONE.
  - Otherwise advance in row-major order (col wraps at COLS-1 to 0 with row++) → CHECK.
- DONE: done=1 for one cycle → IDLE.
- Range check uses unsigned compare against ROWS-1 and COLS-1. There is no wrap-around at board edges, and an out-of-range address is never driven.
- Arithmetic widths:
  - The accumulator is 4 bits and never exceeds 8.
  - bombs_total saturates at ROWS*COLS, which is its maximum anyway.

## Timing
- Reset: synchronous. The next state is IDLE, and every output is 0, including bombs_total, cnt_we, done, and busy.
- Reset mid-scan aborts on the next edge: no further writes, and no done pulse.
- `start` while not in IDLE is ignored. `start` coincident with rst is ignored.
- Cycles per cell:
  - Bomb cell: 3 (CHECK, EVAL, WRITE).
  - Non-bomb cell: 3 + 2×(in-range neighbours) + 1×(out-of-range neighbours).
  - Resulting non-bomb cost: interior 19, edge 16, corner 14.
- Bomb-map read latency is fixed at 1 cycle and there is no stall input.
- done is asserted in the cycle after the final WRITE. cnt_we is never high in the same cycle as done.

## Structure
- Package `buscaminas_pkg` holds:
  - the state enum `bm_state_t`;
  - `CNT_BOMB = 4'hF`;
  - the neighbour offset constants (dr/dc arrays, indices 0..7).
- Sub-module `buscaminas_neighbor_addr` (combinational) takes row, col, and idx and returns n_row, n_col, and in_range.
- The FSM, cell counters, accumulator, and bombs_total register stay in the top module.

## Test plan
- 3×3 board, empty map, start → 9 writes, all cnt_data=0; done asserted 140 cycles after the start edge; bombs_total=0.
- 3×3 board, single bomb at (1,1) → (1,1) written 4'hF, the other 8 cells written 1, bombs_total=1.
- 3×3 board, all bombs → 9 writes of 4'hF, bombs_total=9, done after 28 cycles.
- 8×8 board, bombs at (0,0), (0,1), (1,0) → (1,1)=3 and (0,2)=1; no out-of-range read address is ever driven (assert).
- Reset mid-scan:
  - Assert rst at cell 4 of the 3×3 run → next cycle all outputs are 0, no done pulse.
  - Then start again → a complete correct scan.
- start pulsed while busy → ignored: the write sequence and done timing are identical to a single-start run.
